// File: rtl/uart_rx_buffer.sv
// uart_rx_buffer: receive-side frame FIFO behind the UART receiver.
// Captures {rx_error, rx_data} on each rising edge of rx_done_flag. Errored
// frames can optionally be filtered out. Frames are stored in a circular FIFO
// and presented to the host over a valid/ready read port. Frames lost because
// the FIFO was full are recorded as overflow.
//
// Ports:
//   clock, reset              system clock, async active-high reset
//   rx_done_flag              receiver frame-complete flag (pulse or level)
//   rx_data[7:0]              received byte
//   rx_error[2:0]             {stop, start, parity} error bits
//   drop_errored              discard frames with any error bit set
//   rd_ready                  host accepts the head entry
//   clear_overflow            clears overflow and overflow_count
//   rd_valid                  FIFO non-empty
//   rd_data[7:0]              head byte
//   rd_error[2:0]             head error bits
//   count[ADDR_W:0]           stored entries, 0..DEPTH
//   full, empty               derived from count
//   overflow                  sticky frame-lost flag
//   overflow_count[7:0]       frames lost, saturating at 255
module uart_rx_buffer #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_done_flag,
  input  logic [7:0]        rx_data,
  input  logic [2:0]        rx_error,
  input  logic              drop_errored,
  input  logic              rd_ready,
  input  logic              clear_overflow,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic [2:0]        rd_error,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [7:0]        overflow_count
);

  localparam int unsigned CNT_W   = ADDR_W + 1;
  localparam int unsigned ENTRY_W = 11;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic               done_q;

  logic capture_c;
  logic accept_c;
  logic pop_c;
  logic push_c;
  logic ovf_drop_c;

  // Status flags come straight from the registered count.
  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign rd_valid = ~empty;

  // Head entry is a direct read of the storage at rd_ptr.
  assign rd_data  = mem[rd_ptr][7:0];
  assign rd_error = mem[rd_ptr][10:8];

  // Capture on the rising edge of the done flag, then apply the error filter.
  assign capture_c  = rx_done_flag & ~done_q;
  assign accept_c   = capture_c & ~(drop_errored & (rx_error != 3'd0));
  assign pop_c      = rd_valid & rd_ready;
  // A full FIFO still accepts a frame when the head leaves in the same cycle.
  assign push_c     = accept_c & (~full | pop_c);
  assign ovf_drop_c = accept_c & full & ~pop_c;

  // Done-flag history for edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      done_q <= 1'b0;
    end else begin
      done_q <= rx_done_flag;
    end
  end

  // Frame storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_c) begin
      mem[wr_ptr] <= {rx_error, rx_data};
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      if (push_c && !pop_c) begin
        count <= count + CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Overflow status; a drop in the same cycle as a clear restarts the count at 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow       <= 1'b0;
      overflow_count <= 8'd0;
    end else if (ovf_drop_c) begin
      overflow <= 1'b1;
      if (clear_overflow) begin
        overflow_count <= 8'd1;
      end else if (overflow_count != 8'd255) begin
        overflow_count <= overflow_count + 8'd1;
      end
    end else if (clear_overflow) begin
      overflow       <= 1'b0;
      overflow_count <= 8'd0;
    end
  end

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Testbench for uart_rx_buffer: scenario tasks driven from one initial block,
// with a queue of expected {error, data} entries as the scoreboard.
module tb_uart_rx_buffer;

  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  logic              clock;
  logic              reset;
  logic              rx_done_flag;
  logic [7:0]        rx_data;
  logic [2:0]        rx_error;
  logic              drop_errored;
  logic              rd_ready;
  logic              clear_overflow;
  logic              rd_valid;
  logic [7:0]        rd_data;
  logic [2:0]        rd_error;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              overflow;
  logic [7:0]        overflow_count;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [10:0] sb [$];
  logic        exp_ovf;
  logic [7:0]  exp_ovf_cnt;

  uart_rx_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock          (clock),
    .reset          (reset),
    .rx_done_flag   (rx_done_flag),
    .rx_data        (rx_data),
    .rx_error       (rx_error),
    .drop_errored   (drop_errored),
    .rd_ready       (rd_ready),
    .clear_overflow (clear_overflow),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .rd_error       (rd_error),
    .count          (count),
    .full           (full),
    .empty          (empty),
    .overflow       (overflow),
    .overflow_count (overflow_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model of the capture path: filter, then store or record an overflow.
  task automatic model_capture(input logic [7:0] d, input logic [2:0] e);
    if (!(drop_errored && e != 3'd0)) begin
      if (sb.size() < DEPTH) begin
        sb.push_back({e, d});
      end else begin
        exp_ovf = 1'b1;
        if (exp_ovf_cnt != 8'd255) exp_ovf_cnt = exp_ovf_cnt + 8'd1;
      end
    end
  endtask

  // One-cycle done pulse followed by one idle cycle; called and returns at negedge.
  task automatic send_frame(input logic [7:0] d, input logic [2:0] e);
    rx_done_flag = 1'b1;
    rx_data      = d;
    rx_error     = e;
    @(negedge clock);
    rx_done_flag = 1'b0;
    @(negedge clock);
    model_capture(d, e);
  endtask

  // One-cycle rd_ready pulse; called and returns at negedge.
  task automatic pop_one();
    rd_ready = 1'b1;
    @(negedge clock);
    rd_ready = 1'b0;
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    exp_ovf     = 1'b0;
    exp_ovf_cnt = 8'd0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b exp 1", empty); end
    tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b exp 0", full); end
    tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count got %0d exp 0", count); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b exp 0", overflow); end
    tests_run++; if (overflow_count !== 8'd0) begin tests_failed++; $display("FAIL reset_ovf_cnt got %0d exp 0", overflow_count); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    logic [10:0] h;
    send_frame(8'hA5, 3'b000);
    h = sb[0];
    tests_run++; if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL single_rd_valid got %b exp 1", rd_valid); end
    tests_run++; if (rd_data !== h[7:0]) begin tests_failed++; $display("FAIL single_rd_data got %h exp %h", rd_data, h[7:0]); end
    tests_run++; if (count !== 5'(sb.size())) begin tests_failed++; $display("FAIL single_count got %0d exp %0d", count, sb.size()); end
    pop_one();
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL single_empty_after_pop got %b exp 1", empty); end
  endtask

  task automatic test_held();
    logic [10:0] h;
    rx_done_flag = 1'b1;
    rx_data      = 8'h3C;
    rx_error     = 3'b000;
    repeat (5) @(negedge clock);
    rx_done_flag = 1'b0;
    @(negedge clock);
    model_capture(8'h3C, 3'b000);
    h = sb[0];
    tests_run++; if (count !== 5'(sb.size())) begin tests_failed++; $display("FAIL held_count got %0d exp %0d", count, sb.size()); end
    tests_run++; if (rd_data !== h[7:0]) begin tests_failed++; $display("FAIL held_rd_data got %h exp %h", rd_data, h[7:0]); end
    pop_one();
  endtask

  task automatic test_overflow();
    logic [10:0] h;
    for (int i = 0; i < DEPTH + 3; i++) send_frame(8'(i), 3'b000);
    tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full got %b exp 1", full); end
    tests_run++; if (count !== 5'(sb.size())) begin tests_failed++; $display("FAIL ovf_count got %0d exp %0d", count, sb.size()); end
    tests_run++; if (overflow !== exp_ovf) begin tests_failed++; $display("FAIL ovf_flag got %b exp %b", overflow, exp_ovf); end
    tests_run++; if (overflow_count !== exp_ovf_cnt) begin tests_failed++; $display("FAIL ovf_cnt got %0d exp %0d", overflow_count, exp_ovf_cnt); end
    for (int i = 0; i < DEPTH; i++) begin
      h = sb[0];
      tests_run++;
      if (rd_valid !== 1'b1 || rd_data !== h[7:0]) begin
        tests_failed++; $display("FAIL ovf_drain_%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, h[7:0]);
      end
      pop_one();
    end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL ovf_drained_empty got %b exp 1", empty); end
    clear_overflow = 1'b1;
    @(negedge clock);
    clear_overflow = 1'b0;
    exp_ovf = 1'b0; exp_ovf_cnt = 8'd0;
    tests_run++; if (overflow !== exp_ovf || overflow_count !== exp_ovf_cnt) begin
      tests_failed++; $display("FAIL ovf_clear got %b/%0d exp %b/%0d", overflow, overflow_count, exp_ovf, exp_ovf_cnt);
    end
  endtask

  task automatic test_filter();
    logic [10:0] h;
    for (int pass = 0; pass < 2; pass++) begin
      drop_errored = (pass == 0);
      send_frame(8'h11, 3'b000);
      send_frame(8'h22, 3'b001);
      send_frame(8'h33, 3'b100);
      tests_run++; if (count !== 5'(sb.size())) begin tests_failed++; $display("FAIL filter%0d_count got %0d exp %0d", pass, count, sb.size()); end
      tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL filter%0d_overflow got %b exp 0", pass, overflow); end
      while (sb.size() != 0) begin
        h = sb[0];
        tests_run++;
        if (rd_valid !== 1'b1 || rd_data !== h[7:0] || rd_error !== h[10:8]) begin
          tests_failed++; $display("FAIL filter%0d_entry got %b %h %b exp 1 %h %b", pass, rd_valid, rd_data, rd_error, h[7:0], h[10:8]);
        end
        pop_one();
      end
      tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL filter%0d_empty got %b exp 1", pass, empty); end
    end
    drop_errored = 1'b0;
  endtask

  task automatic test_full_boundary();
    logic [10:0] h;
    for (int i = 0; i < DEPTH; i++) send_frame(8'h40 + 8'(i), 3'(i % 8));
    // Simultaneous push and pop while full.
    rx_done_flag = 1'b1; rx_data = 8'h77; rx_error = 3'b010; rd_ready = 1'b1;
    @(negedge clock);
    rx_done_flag = 1'b0; rd_ready = 1'b0;
    @(negedge clock);
    void'(sb.pop_front());
    sb.push_back({3'b010, 8'h77});
    h = sb[0];
    tests_run++; if (count !== 5'(sb.size())) begin tests_failed++; $display("FAIL fullpp_count got %0d exp %0d", count, sb.size()); end
    tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL fullpp_overflow got %b exp 0", overflow); end
    tests_run++; if (rd_data !== h[7:0]) begin tests_failed++; $display("FAIL fullpp_head got %h exp %h", rd_data, h[7:0]); end
    send_frame(8'h90, 3'b000);
    send_frame(8'h91, 3'b000);
    tests_run++; if (overflow_count !== exp_ovf_cnt) begin tests_failed++; $display("FAIL full_drop_cnt got %0d exp %0d", overflow_count, exp_ovf_cnt); end
    // Clear in the same cycle as a drop: the drop wins and the count restarts at 1.
    rx_done_flag = 1'b1; rx_data = 8'h92; rx_error = 3'b000; clear_overflow = 1'b1;
    @(negedge clock);
    rx_done_flag = 1'b0; clear_overflow = 1'b0;
    @(negedge clock);
    exp_ovf = 1'b1; exp_ovf_cnt = 8'd1;
    tests_run++; if (overflow !== exp_ovf || overflow_count !== exp_ovf_cnt) begin
      tests_failed++; $display("FAIL clear_vs_drop got %b/%0d exp %b/%0d", overflow, overflow_count, exp_ovf, exp_ovf_cnt);
    end
    tests_run++; if (count !== 5'(sb.size())) begin tests_failed++; $display("FAIL clear_vs_drop_count got %0d exp %0d", count, sb.size()); end
  endtask

  task automatic test_async_reset();
    logic [10:0] h;
    apply_reset();
    for (int i = 0; i < 7; i++) send_frame(8'hC0 + 8'(i), 3'b000);
    tests_run++; if (count !== 5'(sb.size())) begin tests_failed++; $display("FAIL prereset_count got %0d exp %0d", count, sb.size()); end
    // Start a capture, then hit reset between clock edges.
    rx_done_flag = 1'b1; rx_data = 8'h5A; rx_error = 3'b000;
    #2 reset = 1'b1;
    #1;
    tests_run++; if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_rd_valid got %b exp 0", rd_valid); end
    tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL areset_count got %0d exp 0", count); end
    tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL areset_empty got %b exp 1", empty); end
    tests_run++; if (overflow_count !== 8'd0) begin tests_failed++; $display("FAIL areset_ovf_cnt got %0d exp 0", overflow_count); end
    sb.delete();
    exp_ovf = 1'b0; exp_ovf_cnt = 8'd0;
    @(negedge clock);
    // Done still high at reset release: first edge captures it.
    reset = 1'b0;
    @(negedge clock);
    rx_done_flag = 1'b0;
    model_capture(8'h5A, 3'b000);
    h = sb[0];
    tests_run++; if (count !== 5'(sb.size())) begin tests_failed++; $display("FAIL post_reset_capture_count got %0d exp %0d", count, sb.size()); end
    tests_run++; if (rd_data !== h[7:0]) begin tests_failed++; $display("FAIL post_reset_capture_data got %h exp %h", rd_data, h[7:0]); end
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1; rx_done_flag = 1'b0; rx_data = 8'h00; rx_error = 3'b000;
    drop_errored = 1'b0; rd_ready = 1'b0; clear_overflow = 1'b0;
    exp_ovf = 1'b0; exp_ovf_cnt = 8'd0;
    test_reset();
    test_single();
    test_held();
    test_overflow();
    test_filter();
    test_full_boundary();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side frame buffer that sits directly downstream of the full-duplex UART receiver. It captures each received byte, together with its 3-bit error status, on the rising edge of the receiver's done flag. Captured frames are stored in a circular FIFO and presented to the host over a valid/ready read port, with overflow detection and optional discard of errored frames.

## Interface
- DEPTH, 16, number of FIFO entries; must be a power of two, ≥ 2.
- ADDR_W, 4, log2(DEPTH).

- clock  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- rx_done_flag  input  1  receiver frame-complete flag; may be a pulse or held high.
- rx_data  input  8  received byte; valid whenever rx_done_flag is high.
- rx_error  input  3  receiver error bits: [0] parity, [1] start, [2] stop.
- drop_errored  input  1  when 1, frames with any rx_error bit set are discarded.
- rd_ready  input  1  host accepts the head entry.
- clear_overflow  input  1  single-cycle clear of overflow status.
- rd_valid  output  1  FIFO non-empty; head entry is on rd_data/rd_error.
- rd_data  output  8  head byte.
- rd_error  output  3  head error bits.
- count  output  ADDR_W+1  number of stored entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky: a frame was lost because the FIFO was full.
- overflow_count  output  8  frames lost to overflow; saturates at 255.

## Operation
- Edge detect: a registered copy done_q tracks rx_done_flag. A capture event occurs when rx_done_flag=1 and done_q=0. A done level held for N cycles yields exactly one capture.
- Capture: rx_data and rx_error are sampled on the same clock edge that detects the event.
- Filter: if drop_errored=1 and rx_error≠0, the capture is silently discarded. Discarded frames do not change count and are not counted as overflow.
- Push: on an accepted capture, {rx_error, rx_data} is written to mem[wr_ptr], and wr_ptr advances modulo DEPTH.
- Pop: when rd_valid && rd_ready, rd_ptr advances modulo DEPTH. rd_ready while empty has no effect.
- Storage: 11-bit × DEPTH register array. rd_data and rd_error are combinational reads of mem[rd_ptr].
- count is updated as follows:
  - +1 on a push without a pop.
  - −1 on a pop without a push.
  - Unchanged when both or neither occur.
- Full boundary:
  - Push while full with a simultaneous pop: accepted, count stays DEPTH.
  - Push while full without a pop: frame dropped, overflow←1, overflow_count incremented and saturating at 255.
- Empty boundary: push while empty produces no same-cycle pop, because rd_valid is still 0.
- Pointers: ADDR_W bits each and wrap naturally. full and empty are derived from count, not from pointer comparison.
- Overflow clear:
  - clear_overflow=1 sets overflow←0 and overflow_count←0.
  - If an overflow drop occurs in the same cycle, the drop wins: overflow←1, overflow_count←1.
- Reset (asynchronous, any time including mid-frame):
  - wr_ptr, rd_ptr, count, done_q, overflow, overflow_count all ←0.
  - Outputs during and after reset: rd_valid=0, empty=1, full=0, count=0, overflow=0, overflow_count=0.
  - rd_data and rd_error are undefined while empty; mem contents need not be reset.
  - If rx_done_flag is already high when reset deasserts, the first clock edge registers a capture, because done_q was reset to 0.

## Timing
- Capture latency: rx_done_flag rises before edge N, so the push happens at edge N. After edge N, rd_valid=1 and count has incremented; rd_data is visible from that point.
- Pop latency: rd_ready high with rd_valid at edge M frees the entry at edge M. The next head appears after edge M, in the same cycle.
- Throughput: one push and one pop per cycle maximum. The UART delivers at most one frame per many clocks, so the FIFO never back-pressures the receiver.
- No combinational path from rd_ready to rd_valid or rd_data.

## Test plan
- Reset, then a single rx_done_flag pulse with rx_data=0xA5, rx_error=0 → one cycle later rd_valid=1, rd_data=0xA5, count=1; pop with rd_ready → empty=1.
- rx_done_flag held high for 5 cycles with rx_data=0x3C → exactly one entry (count=1), not five.
- DEPTH+3 frames 0x00..0x12 with no reads → full=1, count=16, overflow=1, overflow_count=3. Reads then return 0x00..0x0F in order, with pointer wrap exercised.
- drop_errored=1, frames 0x11 (err=3'b000), 0x22 (err=3'b001), 0x33 (err=3'b100) → only 0x11 stored. Repeat with drop_errored=0 → all three stored, rd_error values preserved.
- FIFO full with rd_ready=1 while a capture arrives → push and pop in the same cycle, count stays 16, overflow stays 0. Next: clear_overflow in the same cycle as an overflow drop → overflow=1, overflow_count=1.
- Assert reset asynchronously with count=7 and mid-capture → outputs immediately reset: rd_valid=0, count=0, empty=1, overflow_count=0.
